// File: rtl/display_scan.sv
// Time-multiplexed N-digit segment driver with frame shadow buffer, blank/blink, PWM brightness and dead time.
// Outputs are registered: pins in cycle t+1 reflect counter/shadow state of cycle t; no backpressure.
module display_scan #(
    parameter int NUM_DIGITS     = 8,
    parameter int SEG_W          = 7,
    parameter int SCAN_DIV       = 1350,
    parameter int DEAD_TICKS     = 2,
    parameter int BRIGHT_W       = 3,
    parameter int BLINK_DIV      = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_enable,
    input  logic [NUM_DIGITS*SEG_W-1:0] i_frame_in,
    input  logic [NUM_DIGITS-1:0]       i_blank_mask,
    input  logic [NUM_DIGITS-1:0]       i_blink_mask,
    input  logic [BRIGHT_W-1:0]         i_brightness,
    output logic [SEG_W-1:0]            o_seg_out,
    output logic [NUM_DIGITS-1:0]       o_sel_out,
    output logic                        o_frame_start
);
    localparam int TW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int PW = TW + BRIGHT_W + 1;

    localparam logic [TW-1:0]         TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0]         FC_LAST   = FW'(BLINK_DIV - 1);
    localparam logic [PW-1:0]         DEAD      = PW'(DEAD_TICKS);
    localparam logic [SEG_W-1:0]      SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF   = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t                      r_state;
    logic [TW-1:0]               r_tick;
    logic [IW-1:0]               r_idx;
    logic [FW-1:0]               r_frame_cnt;
    logic                        r_blink_ph;
    logic [NUM_DIGITS*SEG_W-1:0] r_sh_frame;
    logic [NUM_DIGITS-1:0]       r_sh_blank;
    logic [NUM_DIGITS-1:0]       r_sh_blink;
    logic                        r_sh_ph;
    logic [PW-1:0]               r_sh_on;
    logic [SEG_W-1:0]            r_seg;
    logic [NUM_DIGITS-1:0]       r_sel;
    logic                        r_fs;

    logic                        w_load;
    logic [PW-1:0]               w_prod;
    logic [PW-1:0]               w_on_new;
    logic [NUM_DIGITS*SEG_W-1:0] w_frame;
    logic [NUM_DIGITS-1:0]       w_blank;
    logic [NUM_DIGITS-1:0]       w_blink;
    logic                        w_ph;
    logic [PW-1:0]               w_on;
    logic [PW-1:0]               w_tick_ext;
    logic                        w_lit;
    logic [SEG_W-1:0]            w_seg_act;
    logic [NUM_DIGITS-1:0]       w_sel_act;

    assign w_load   = i_enable && (r_tick == '0) && (r_idx == '0);
    assign w_prod   = (PW'(i_brightness) + PW'(1)) * PW'(SCAN_DIV);
    assign w_on_new = w_prod >> BRIGHT_W;

    // On a load cycle the freshly captured values already govern this slot.
    assign w_frame = w_load ? i_frame_in   : r_sh_frame;
    assign w_blank = w_load ? i_blank_mask : r_sh_blank;
    assign w_blink = w_load ? i_blink_mask : r_sh_blink;
    assign w_ph    = w_load ? r_blink_ph   : r_sh_ph;
    assign w_on    = w_load ? w_on_new     : r_sh_on;

    assign w_tick_ext = PW'(r_tick);
    assign w_lit = i_enable && (w_tick_ext >= DEAD) && (w_tick_ext < w_on)
                   && !w_blank[r_idx] && !(w_blink[r_idx] && w_ph);

    assign w_seg_act = w_lit ? w_frame[r_idx*SEG_W +: SEG_W] : '0;
    assign w_sel_act = w_lit ? (NUM_DIGITS'(1) << r_idx) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_blink_ph  <= 1'b0;
            r_sh_frame  <= '0;
            r_sh_blank  <= '0;
            r_sh_blink  <= '0;
            r_sh_ph     <= 1'b0;
            r_sh_on     <= '0;
            r_seg       <= SEG_OFF;
            r_sel       <= SEL_OFF;
            r_fs        <= 1'b0;
        end else begin
            r_seg <= w_seg_act ^ SEG_OFF;
            r_sel <= w_sel_act ^ SEL_OFF;
            r_fs  <= w_load;

            case (r_state)
                S_IDLE:  if (i_enable)  r_state <= S_SCAN;
                S_SCAN:  if (!i_enable) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (i_enable) begin
                if (w_load) begin
                    r_sh_frame <= i_frame_in;
                    r_sh_blank <= i_blank_mask;
                    r_sh_blink <= i_blink_mask;
                    r_sh_ph    <= r_blink_ph;
                    r_sh_on    <= w_on_new;
                end
                if (r_tick == TICK_LAST) begin
                    r_tick <= '0;
                    if (r_idx == IDX_LAST) begin
                        r_idx <= '0;
                        if (r_frame_cnt == FC_LAST) begin
                            r_frame_cnt <= '0;
                            r_blink_ph  <= ~r_blink_ph;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + FW'(1);
                        end
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end else begin
                    r_tick <= r_tick + TW'(1);
                end
            end
        end
    end

    assign o_seg_out     = r_seg;
    assign o_sel_out     = r_sel;
    assign o_frame_start = r_fs;
endmodule

// File: doc/display_scan.md
# display_scan

Parametrised time-multiplexed driver for N-digit seven-segment (or wider) displays. It sits between the game/menu logic, which produces one segment pattern per digit, and the board pins, and scans one digit per slot. Compared with the fixed 8-digit scanner, it adds a synchronous reset, a frame-coherent shadow buffer, per-digit blanking and blinking, PWM brightness, anti-ghosting dead time and configurable pin polarity.

## Interface
- NUM_DIGITS, 8: digits scanned, legal range 2..16; does not need to be a power of two.
- SEG_W, 7: segment lines per digit.
- SCAN_DIV, 1350: clk cycles per digit slot; must be ≥ DEAD_TICKS+2.
- DEAD_TICKS, 2: cycles at the start of each slot with the selector inactive.
- BRIGHT_W, 3: brightness code width.
- BLINK_DIV, 64: frames per blink half-period; must be ≥ 1.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment drives 0.
- SEL_ACTIVE_LOW, 0: 1 means the selected digit drives 0.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  0 freezes scanning and drives all outputs inactive.
- frame_in  in  NUM_DIGITS*SEG_W  digit k occupies [k*SEG_W +: SEG_W]; 1 means the segment is lit.
- blank_mask  in  NUM_DIGITS  1 forces the digit dark.
- blink_mask  in  NUM_DIGITS  1 makes the digit dark during the blink-off phase.
- brightness  in  BRIGHT_W  on-time code; 0 is dimmest.
- seg_out  out  SEG_W  segment pins, polarity set by SEG_ACTIVE_LOW.
- sel_out  out  NUM_DIGITS  one-hot digit select, polarity set by SEL_ACTIVE_LOW; bit k drives digit k.
- frame_start  out  1  one-cycle pulse aligned with the first output cycle of digit 0.

## Operation
- **Counters**
  - tick (0..SCAN_DIV-1) increments every enabled cycle.
  - At SCAN_DIV-1, tick returns to 0 and idx advances.
  - idx runs 0..NUM_DIGITS-1, then wraps to 0.
  - frame_cnt runs 0..BLINK_DIV-1 and increments on each idx wrap. When frame_cnt wraps, blink_ph toggles.
- **Shadow load**
  - Occurs on any cycle with enable=1, tick=0 and idx=0.
  - Captures frame_in, blank_mask, blink_mask, blink_ph and on_ticks = ((brightness+1)*SCAN_DIV) >> BRIGHT_W.
  - The product uses $clog2(SCAN_DIV)+BRIGHT_W+1 bits; no truncation before the shift.
  - Input changes mid-frame are invisible until the next load.
  - The first enabled cycle after reset is a load cycle.
- **Lit condition** for digit idx, all terms from shadow values:
  - DEAD_TICKS ≤ tick < on_ticks,
  - and blank bit = 0,
  - and not (blink bit = 1 and blink_ph = 1).
- **Output drive**
  - Lit: sel_out is the one-hot of idx and seg_out is the shadow segments, each polarity-adjusted.
  - Otherwise: sel_out is all inactive and seg_out is all inactive.
  - Inactive level is all-ones for an active-low output, all-zeros for an active-high one.
- **enable=0**
  - All counters and shadows hold.
  - Outputs go inactive; frame_start = 0.
  - Scanning resumes at the held idx and tick when enable returns to 1.
- **States**
  - IDLE: after reset or enable=0. Moves to SCAN on enable=1.
  - SCAN: moves to IDLE on enable=0.
  - rst from any state goes to IDLE.

## Timing
- Reset values:
  - tick=0, idx=0, frame_cnt=0, blink_ph=0, shadows=0.
  - seg_out and sel_out inactive, frame_start=0.
  - All outputs take these values the cycle after rst is sampled high.
- All outputs are registered with 1-cycle latency: the pins in cycle t+1 reflect the counter and shadow state of cycle t.
- Frame period is NUM_DIGITS*SCAN_DIV enabled cycles. frame_start pulses exactly once per frame, in the cycle after the load.
- A digit is selected for max(0, min(on_ticks,SCAN_DIV) − DEAD_TICKS) cycles per slot. A brightness code giving on_ticks ≤ DEAD_TICKS leaves the display fully dark; this is legal.
- Consecutive digits are never selected in adjacent cycles, provided DEAD_TICKS ≥ 1.
- rst takes priority over enable. A reset mid-frame restarts at idx 0 with a load on the first enabled cycle.

## Test plan
Bench parameters: NUM_DIGITS=5, SCAN_DIV=8, DEAD_TICKS=1, BRIGHT_W=3, BLINK_DIV=2, SEG_ACTIVE_LOW=1, SEL_ACTIVE_LOW=0.
- **Reset and rotation.**
  - Stimulus: rst for 3 cycles, then enable=1, brightness=7.
  - Required: seg_out=7'h7F and sel_out=0 during reset. sel_out then walks 00001→00010→…→10000→00001, with 7 active cycles per 8-cycle slot. frame_start pulses every 40 cycles.
- **Brightness.**
  - Stimulus: brightness=3, giving on_ticks=4.
  - Required: each sel bit is active for exactly 3 cycles per slot.
  - Stimulus: brightness=0, giving on_ticks=1.
  - Required: sel_out stays 0 for the whole frame.
- **Tear-free update.**
  - Stimulus: set digit-0 segments to 7'h3F mid-frame.
  - Required: seg_out shows ~7'h3F only from the next frame_start onward.
- **Blank and blink.**
  - Stimulus: blank_mask=5'b10000, blink_mask=5'b00010.
  - Required: digit 4 is never selected. Digit 1 is dark in frames 2,3,6,7,… and lit in frames 0,1,4,5,…
- **Enable gating.**
  - Stimulus: drop enable at idx=2, tick=4 for 10 cycles.
  - Required: outputs go inactive the next cycle. On re-enable, digit 2 resumes at tick 4 with no extra frame_start.
- **Reset mid-frame.**
  - Stimulus: assert rst at idx=3.
  - Required: outputs inactive the next cycle. After release, the first frame_start is followed by digit 0 being selected.
